// File: rtl/adder4_serial_ctrl.sv
// Serial operand loader and result capture stage wrapped around the combinational adder4.
// Optional accumulate mode (X reloaded from the previous sum) is enabled by ADDER4_SERIAL_ACCUM_EN.
module adder4_serial_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din,
    input  logic       in_valid,
`ifdef ADDER4_SERIAL_ACCUM_EN
    input  logic       acc_mode,
`endif
    output logic       in_ready,
    output logic       x_0,
    output logic       x_1,
    output logic       x_2,
    output logic       x_3,
    output logic       y_0,
    output logic       y_1,
    output logic       y_2,
    output logic       y_3,
    output logic       c_in,
    input  logic       s_0,
    input  logic       s_1,
    input  logic       s_2,
    input  logic       s_3,
    input  logic       c_out,
    output logic [3:0] sum,
    output logic       carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOAD, ADD, HOLD} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       go;
    logic       acc;

`ifdef ADDER4_SERIAL_ACCUM_EN
    assign acc = acc_mode;
`else
    assign acc = 1'b0;
`endif

    // HOLD may restart only on the handshake cycle, so the result is never dropped.
    assign go = start && ((state == IDLE) || ((state == HOLD) && out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            x_0       <= 1'b0;
            x_1       <= 1'b0;
            x_2       <= 1'b0;
            x_3       <= 1'b0;
            y_0       <= 1'b0;
            y_1       <= 1'b0;
            y_2       <= 1'b0;
            y_3       <= 1'b0;
            c_in      <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else if (go) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            if (acc) begin
                cnt <= 4'd4;
                x_0 <= sum[3];
                x_1 <= sum[2];
                x_2 <= sum[1];
                x_3 <= sum[0];
            end else begin
                cnt <= 4'd0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        case (cnt)
                            4'd0:    x_0  <= din;
                            4'd1:    x_1  <= din;
                            4'd2:    x_2  <= din;
                            4'd3:    x_3  <= din;
                            4'd4:    y_0  <= din;
                            4'd5:    y_1  <= din;
                            4'd6:    y_2  <= din;
                            4'd7:    y_3  <= din;
                            default: c_in <= din;
                        endcase
                        if (cnt == 4'd8) begin
                            state    <= ADD;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ADD: begin
                    sum       <= {s_0, s_1, s_2, s_3};
                    carry     <= c_out;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder4_serial_ctrl.sv
// Directed plus randomized bench for adder4_serial_ctrl with a behavioural adder4 in the loop.
// Exercises accumulate mode too when ADDER4_SERIAL_ACCUM_EN is defined.
module tb_adder4_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, din, in_valid, out_ready, acc_mode;
    logic       in_ready, x_0, x_1, x_2, x_3, y_0, y_1, y_2, y_3, c_in;
    logic       s_0, s_1, s_2, s_3, c_out;
    logic [3:0] sum;
    logic       carry, out_valid, busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          op_id    = 0;
    logic [3:0]  last_sum = '0;

    always #5 clk = ~clk;

    // Environment model of the combinational adder4 the controller drives.
    logic [4:0] add_r;
    assign add_r = {1'b0, x_0, x_1, x_2, x_3} + {1'b0, y_0, y_1, y_2, y_3} + {4'b0, c_in};
    assign {c_out, s_0, s_1, s_2, s_3} = add_r;

    adder4_serial_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .in_valid(in_valid),
`ifdef ADDER4_SERIAL_ACCUM_EN
        .acc_mode(acc_mode),
`endif
        .in_ready(in_ready),
        .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3),
        .y_0(y_0), .y_1(y_1), .y_2(y_2), .y_3(y_3),
        .c_in(c_in),
        .s_0(s_0), .s_1(s_1), .s_2(s_2), .s_3(s_3), .c_out(c_out),
        .sum(sum), .carry(carry), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL op%0d %s: observed %0h expected %0h", op_id, name, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_xyc"}, {7'b0, x_0, x_1, x_2, x_3, y_0, y_1, y_2, y_3, c_in}, '0);
        chk({name, "_sum"}, {11'b0, carry, sum}, '0);
        chk({name, "_flags"}, {13'b0, out_valid, in_ready, busy}, '0);
    endtask

    // Runs one operation starting from IDLE or HOLD (start and out_ready raised together),
    // and leaves the DUT holding the result with out_ready low.
    task automatic do_op(input logic [3:0] xo, input logic [3:0] yo, input logic ci,
                         input logic acc, input int stall_at, input int stall_len,
                         input int hold_len);
        logic [3:0] xe;
        logic [4:0] exp_r;
        int         first;
        op_id++;
        xe    = acc ? last_sum : xo;
        exp_r = {1'b0, xe} + {1'b0, yo} + {4'b0, ci};
        first = acc ? 4 : 0;
        start = 1'b1; out_ready = 1'b1; acc_mode = acc; in_valid = 1'b0;
        tick;
        start = 1'b0; out_ready = 1'b0; acc_mode = 1'b0;
        chk("in_ready_load", {15'b0, in_ready}, 16'd1);
        chk("busy_load", {15'b0, busy}, 16'd1);
        chk("valid_load", {15'b0, out_valid}, 16'd0);
        for (int b = first; b <= 8; b++) begin
            if (b == stall_at) begin
                in_valid = 1'b0;
                din = 1'($urandom);
                for (int k = 0; k < stall_len; k++) begin
                    tick;
                    chk("stall_ready", {15'b0, in_ready}, 16'd1);
                    chk("stall_valid", {15'b0, out_valid}, 16'd0);
                end
            end
            in_valid = 1'b1;
            if (b < 4)      din = xo[3 - b];
            else if (b < 8) din = yo[7 - b];
            else            din = ci;
            start = 1'($urandom);
            tick;
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("add_ready", {15'b0, in_ready}, 16'd0);
        chk("add_valid", {15'b0, out_valid}, 16'd0);
        tick;
        chk("hold_valid", {15'b0, out_valid}, 16'd1);
        chk("x_operand", {12'b0, x_0, x_1, x_2, x_3}, {12'b0, xe});
        chk("y_operand", {12'b0, y_0, y_1, y_2, y_3}, {12'b0, yo});
        chk("result", {11'b0, carry, sum}, {11'b0, exp_r});
        chk("hold_flags", {14'b0, in_ready, busy}, 16'd1);
        last_sum = exp_r[3:0];
        for (int k = 0; k < hold_len; k++) begin
            start = 1'b1;
            tick;
            chk("bp_valid", {15'b0, out_valid}, 16'd1);
            chk("bp_result", {11'b0, carry, sum}, {11'b0, exp_r});
            chk("bp_ready", {15'b0, in_ready}, 16'd0);
        end
        start = 1'b0;
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("idle_flags", {13'b0, out_valid, in_ready, busy}, 16'd0);
        chk("idle_sum", {12'b0, sum}, {12'b0, last_sum});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; din = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; acc_mode = 1'b0;
        tick; tick;
        check_reset_vals("reset_held");
        rst_n = 1'b1;
        tick;
        check_reset_vals("reset_released");

        do_op(4'b0001, 4'b0010, 1'b0, 1'b0, 99, 0, 0);
        release_result;
        do_op(4'b0101, 4'b0101, 1'b1, 1'b0, 99, 0, 0);
        release_result;
        do_op(4'b1111, 4'b0000, 1'b1, 1'b0, 99, 0, 0);
        release_result;
        do_op(4'b1111, 4'b0001, 1'b0, 1'b0, 99, 0, 0);
        release_result;

        // input stall after beat 4, then 5 cycles of backpressure with start asserted
        do_op(4'b0110, 4'b0011, 1'b1, 1'b0, 5, 3, 5);
        // back-to-back restart from HOLD
        do_op(4'b1000, 4'b1000, 1'b0, 1'b0, 99, 0, 0);
        release_result;

        // asynchronous reset in the middle of LOAD
        op_id++;
        start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 6; b++) begin
            din = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        last_sum = '0;
        tick;
        rst_n = 1'b1;
        tick;
        check_reset_vals("after_async_reset");
        do_op(4'b0111, 4'b0001, 1'b0, 1'b0, 99, 0, 0);
        release_result;

        for (int i = 0; i < 24; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'b0,
                  $urandom_range(0, 12), $urandom_range(1, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) release_result;
        end
        release_result;

`ifdef ADDER4_SERIAL_ACCUM_EN
        do_op(4'b0011, 4'b0001, 1'b0, 1'b0, 99, 0, 0);
        release_result;
        do_op(4'b0000, 4'b0101, 1'b1, 1'b1, 99, 0, 0);
        chk("acc_directed", {11'b0, carry, sum}, 16'b01010);
        release_result;
        for (int i = 0; i < 16; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 12), $urandom_range(1, 2), $urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) release_result;
        end
        release_result;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
